// File: rtl/alu_mdu_if.sv
// Request/response bundle for alu_mdu.
// master drives requests and out_ready; slave (the block) drives the result side.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             ovf;
    logic             dbz;
    logic             illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, result_hi,
        input  zero, ovf, dbz, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, result_hi,
        output zero, ovf, dbz, illegal
    );
endinterface

// File: rtl/alu_mdu.sv
// ALU with optional iterative unsigned multiply/divide (macro ALU_MDU_MULDIV_EN).
// Ports: clk, rst (sync, active-high), bus (alu_mdu_if.slave: request a/b/op, registered result/flags).
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst,
    alu_mdu_if.slave bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_NOR = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;
    logic             ill_q, ill_d;

    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] alu_res, alu_hi;
    logic             alu_ovf, alu_dbz, alu_ill;

    assign sum  = bus.a + bus.b;
    assign diff = bus.a - bus.b;

`ifdef ALU_MDU_MULDIV_EN
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam int         CW       = $clog2(WIDTH);

    logic             alu_mdu;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] wh_q, wh_d;
    logic [WIDTH-1:0] wl_q, wl_d;
    logic             div_q, div_d;
    logic [WIDTH:0]   m_sum, d_rem, d_try;
    logic [WIDTH-1:0] it_hi, it_lo;

    // One iteration. Multiply: {wh,wl} holds partial product over the
    // multiplier, shifted right each step. Divide: wh is the partial
    // remainder, wl shifts dividend bits out and quotient bits in.
    always_comb begin
        m_sum = {1'b0, wh_q} + (wl_q[0] ? {1'b0, opnd_q} : '0);
        d_rem = {wh_q, wl_q[WIDTH-1]};
        d_try = d_rem - {1'b0, opnd_q};
        if (div_q) begin
            if (d_try[WIDTH]) begin
                it_hi = d_rem[WIDTH-1:0];
                it_lo = {wl_q[WIDTH-2:0], 1'b0};
            end else begin
                it_hi = d_try[WIDTH-1:0];
                it_lo = {wl_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            it_hi = m_sum[WIDTH:1];
            it_lo = {m_sum[0], wl_q[WIDTH-1:1]};
        end
    end
`endif

    // Single-cycle result, also covers illegal codes and divide by zero
    always_comb begin
        alu_res = '0;
        alu_hi  = '0;
        alu_ovf = 1'b0;
        alu_dbz = 1'b0;
        alu_ill = 1'b0;
`ifdef ALU_MDU_MULDIV_EN
        alu_mdu = 1'b0;
`endif
        unique case (bus.op)
            OP_AND: alu_res = bus.a & bus.b;
            OP_OR:  alu_res = bus.a | bus.b;
            OP_XOR: alu_res = bus.a ^ bus.b;
            OP_NOR: alu_res = ~(bus.a | bus.b);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}},
                               $signed(bus.a) < $signed(bus.b)};
`ifdef ALU_MDU_MULDIV_EN
            OP_MULTU: alu_mdu = 1'b1;
            OP_DIVU: begin
                if (bus.b == '0) begin
                    alu_res = '1;
                    alu_hi  = bus.a;
                    alu_dbz = 1'b1;
                end else begin
                    alu_mdu = 1'b1;
                end
            end
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;
        ill_d    = ill_q;
`ifdef ALU_MDU_MULDIV_EN
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        wh_d     = wh_q;
        wl_d     = wl_q;
        div_d    = div_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d  = DONE;
                    result_d = alu_res;
                    hi_d     = alu_hi;
                    zero_d   = (alu_res == '0);
                    ovf_d    = alu_ovf;
                    dbz_d    = alu_dbz;
                    ill_d    = alu_ill;
`ifdef ALU_MDU_MULDIV_EN
                    if (alu_mdu) begin
                        state_d = BUSY;
                        cnt_d   = '0;
                        div_d   = bus.op[0];
                        wh_d    = '0;
                        opnd_d  = bus.op[0] ? bus.b : bus.a;
                        wl_d    = bus.op[0] ? bus.a : bus.b;
                    end
`endif
                end
            end
            BUSY: begin
`ifdef ALU_MDU_MULDIV_EN
                wh_d  = it_hi;
                wl_d  = it_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = DONE;
                    result_d = it_lo;
                    hi_d     = it_hi;
                    zero_d   = (it_lo == '0);
                    ovf_d    = 1'b0;
                    dbz_d    = 1'b0;
                    ill_d    = 1'b0;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            ill_q    <= 1'b0;
`ifdef ALU_MDU_MULDIV_EN
            cnt_q    <= '0;
            opnd_q   <= '0;
            wh_q     <= '0;
            wl_q     <= '0;
            div_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
            ill_q    <= ill_d;
`ifdef ALU_MDU_MULDIV_EN
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            wh_q     <= wh_d;
            wl_q     <= wl_d;
            div_q    <= div_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.result_hi = hi_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
    assign bus.dbz       = dbz_q;
    assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Testbench for alu_mdu: directed vector table, hand-written handshake/reset
// sequences and random requests checked against an arithmetic reference model.
module tb_alu_mdu;
    localparam int W = 32;
`ifdef ALU_MDU_MULDIV_EN
    localparam int ML = W + 1;
`endif

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         o;
        logic         d;
        logic         il;
        int           lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad = 0;

    alu_mdu_if #(.WIDTH(W)) bus ();

    alu_mdu #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] res,
                                input logic [W-1:0] hi, input logic z,
                                input logic o, input logic d, input logic il,
                                input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.hi = hi;
        v.z = z; v.o = o; v.d = d; v.il = il; v.lat = lat;
        return v;
    endfunction

    // Reference model from plain arithmetic
    function automatic vec_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        vec_t v;
        longint sa, sb, s;
        logic [2*W-1:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        v = mk(op, a, b, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        case (op)
            4'b0000: v.res = a & b;
            4'b0001: v.res = a | b;
            4'b0011: v.res = a ^ b;
            4'b0100: v.res = ~(a | b);
            4'b0010: begin
                s = sa + sb;
                v.res = a + b;
                v.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                s = sa - sb;
                v.res = a - b;
                v.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: v.res = (sa < sb) ? 1 : 0;
`ifdef ALU_MDU_MULDIV_EN
            4'b1000: begin
                p = 64'(a) * 64'(b);
                v.res = p[W-1:0];
                v.hi = p[2*W-1:W];
                v.lat = ML;
            end
            4'b1001: begin
                if (b == 0) begin
                    v.res = '1;
                    v.hi = a;
                    v.d = 1'b1;
                end else begin
                    v.res = a / b;
                    v.hi = a % b;
                    v.lat = ML;
                end
            end
`endif
            default: v.il = 1'b1;
        endcase
        v.z = (v.res == 0);
        return v;
    endfunction

    task automatic run(input vec_t v, output vec_t g);
        @(negedge clk);
        chk("in_ready_pre", 64'(bus.in_ready), 64'(1));
        bus.in_valid = 1'b1;
        bus.op = v.op;
        bus.a = v.a;
        bus.b = v.b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op = 4'($urandom);
        bus.a = $urandom;
        bus.b = $urandom;
        g = v;
        g.lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                g.lat = k;
                break;
            end
        end
        g.res = bus.result;
        g.hi = bus.result_hi;
        g.z = bus.zero;
        g.o = bus.ovf;
        g.d = bus.dbz;
        g.il = bus.illegal;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("in_ready_post", 64'(bus.in_ready), 64'(1));
        chk("out_valid_post", 64'(bus.out_valid), 64'(0));
    endtask

    task automatic cmp(input string nm, input vec_t g, input vec_t e);
        chk({nm, ".result"}, 64'(g.res), 64'(e.res));
        chk({nm, ".result_hi"}, 64'(g.hi), 64'(e.hi));
        chk({nm, ".zero"}, 64'(g.z), 64'(e.z));
        chk({nm, ".ovf"}, 64'(g.o), 64'(e.o));
        chk({nm, ".dbz"}, 64'(g.d), 64'(e.d));
        chk({nm, ".illegal"}, 64'(g.il), 64'(e.il));
        chk({nm, ".latency"}, 64'(g.lat), 64'(e.lat));
    endtask

    task automatic chk_zero_outs(input string nm);
        chk({nm, ".out_valid"}, 64'(bus.out_valid), 64'(0));
        chk({nm, ".in_ready"}, 64'(bus.in_ready), 64'(1));
        chk({nm, ".result"}, 64'(bus.result), 64'(0));
        chk({nm, ".result_hi"}, 64'(bus.result_hi), 64'(0));
        chk({nm, ".zero"}, 64'(bus.zero), 64'(0));
        chk({nm, ".ovf"}, 64'(bus.ovf), 64'(0));
        chk({nm, ".dbz"}, 64'(bus.dbz), 64'(0));
        chk({nm, ".illegal"}, 64'(bus.illegal), 64'(0));
    endtask

    initial begin
        vec_t tbl[$];
        vec_t g, e;
        logic [3:0] codes [9];
        logic [3:0] op;
        logic [W-1:0] ra, rb;

        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                  4'b0011, 4'b0100, 4'b1000, 4'b1001};

        tbl.push_back(mk(4'b0010, 15, 10, 25, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(4'b0110, 15, 10, 5, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(4'b0000, 12, 5, 4, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(4'b0001, 12, 5, 13, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(4'b0111, 32'hFFFFFFFF, 1, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(4'b0111, 1, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(4'b0010, 32'h7FFFFFFF, 1, 32'h80000000, 0,
                         0, 1, 0, 0, 1));
        tbl.push_back(mk(4'b0110, 5, 5, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(4'b0110, 32'h80000000, 1, 32'h7FFFFFFF, 0,
                         0, 1, 0, 0, 1));
        tbl.push_back(mk(4'b0011, 32'hF0F0, 32'hFF00, 32'h0FF0, 0,
                         0, 0, 0, 0, 1));
        tbl.push_back(mk(4'b0100, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(4'b1111, 7, 3, 0, 0, 1, 0, 0, 1, 1));
`ifdef ALU_MDU_MULDIV_EN
        tbl.push_back(mk(4'b1000, 32'hFFFFFFFF, 2, 32'hFFFFFFFE, 1,
                         0, 0, 0, 0, 33));
        tbl.push_back(mk(4'b1001, 100, 7, 14, 2, 0, 0, 0, 0, 33));
        tbl.push_back(mk(4'b1001, 9, 0, 32'hFFFFFFFF, 9, 0, 0, 1, 0, 1));
        tbl.push_back(mk(4'b1000, 0, 5, 0, 0, 1, 0, 0, 0, 33));
`else
        tbl.push_back(mk(4'b1000, 32'hFFFFFFFF, 2, 0, 0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(4'b1001, 100, 7, 0, 0, 1, 0, 0, 1, 1));
`endif

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero_outs("reset");

        foreach (tbl[i]) begin
            run(tbl[i], g);
            cmp($sformatf("vec%0d", i), g, tbl[i]);
        end

        // Backpressure: result held, requests ignored while DONE
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = 4'b0010;
        bus.a = 3;
        bus.b = 4;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp.valid0", 64'(bus.out_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.op = 4'b0110;
            bus.a = $urandom;
            bus.b = $urandom;
            @(posedge clk);
            @(negedge clk);
            chk("bp.valid", 64'(bus.out_valid), 64'(1));
            chk("bp.result", 64'(bus.result), 64'(7));
            chk("bp.ovf", 64'(bus.ovf), 64'(0));
            chk("bp.in_ready", 64'(bus.in_ready), 64'(0));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("bp.release_valid", 64'(bus.out_valid), 64'(0));
        chk("bp.release_ready", 64'(bus.in_ready), 64'(1));
        @(negedge clk);
        chk("bp.no_accept", 64'(bus.out_valid), 64'(0));

        // Reset during a multiply
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = 4'b1000;
        bus.a = 32'hFFFFFFFF;
        bus.b = 2;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_zero_outs("midrst");
        @(negedge clk);
        chk("midrst.stay_idle", 64'(bus.out_valid), 64'(0));
        e = mk(4'b0010, 1, 1, 2, 0, 0, 0, 0, 0, 1);
        run(e, g);
        cmp("after_rst", g, e);

        // Random requests against the model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) op = 4'($urandom);
            else op = codes[$urandom_range(0, 8)];
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 4) == 0) rb = '0;
            if ($urandom_range(0, 4) == 0) rb = W'($urandom_range(1, 20));
            e = model(op, ra, rb);
            run(e, g);
            cmp($sformatf("rnd%0d_op%0h", i, op), g, e);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 4..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  4  operation code.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 out_valid  output  1  result registers valid.
REQ-009 out_ready  input  1  consumer takes result.
REQ-010 result  output  WIDTH  primary result (LO or quotient for MDU ops).
REQ-011 result_hi  output  WIDTH  HI product or remainder; 0 for non-MDU ops.
REQ-012 zero  output  1  result == 0.
REQ-013 ovf  output  1  signed overflow, ADD/SUB only, else 0.
REQ-014 dbz  output  1  divide-by-zero flag, DIVU only, else 0.
REQ-015 illegal  output  1  undefined op code accepted.

Function
REQ-016 Op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 0011 XOR, 0100 NOR, 1000 MULTU, 1001 DIVU; all others illegal.
REQ-017 FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-018 Accept = in_valid & in_ready at a rising edge; op, a, b captured at that edge; inputs ignored at all other times.
REQ-019 Single-cycle ops, illegal ops, DIVU with b == 0: result computed and registered at the accept edge; IDLE -> DONE; out_valid high the following cycle.
REQ-020 MULTU: unsigned shift-add, one bit per cycle; IDLE -> BUSY at accept, exactly WIDTH cycles in BUSY, then DONE; {result_hi, result} = a*b, 2*WIDTH bits.
REQ-021 DIVU (b != 0): unsigned restoring division, one bit per cycle; same timing as MULTU; result = a/b, result_hi = a%b.
REQ-022 DIVU with b == 0: result all ones, result_hi = a, dbz = 1.
REQ-023 Illegal op: result 0, result_hi 0, illegal = 1, zero = 1.
REQ-024 ADD/SUB wrap modulo 2^WIDTH; ovf set on signed overflow.
REQ-025 SLT: result = 1 if signed a < signed b, else 0; upper bits 0.
REQ-026 zero reflects result only; result_hi is ignored.
REQ-027 out_valid = 1 only in DONE; all outputs held stable while out_valid & !out_ready.
REQ-028 DONE -> IDLE on the edge where out_ready = 1; no new accept on that edge.
REQ-029 Outputs are registered; no combinational path from a, b, op to any output.

Reset
REQ-030 rst forces IDLE on the next edge from any state, including mid-BUSY; the in-flight operation is discarded.
REQ-031 After reset: out_valid 0, in_ready 1, result 0, result_hi 0, zero 0, ovf 0, dbz 0, illegal 0, iteration counter 0.
REQ-032 rst has priority over accept and over out_ready on the same edge.

Configuration
REQ-033 Macro ALU_MDU_MULDIV_EN: when defined, MULTU and DIVU are implemented per REQ-020..022.
REQ-034 When not defined, codes 1000 and 1001 are illegal (REQ-023), BUSY is never entered, and no multiply/divide datapath or counter is synthesised.

Verification
REQ-035 WIDTH=32; ADD 15+10 -> result 25, zero 0; SUB 15-10 -> 5; AND 12,5 -> 4; OR 12,5 -> 13; SLT 0xFFFFFFFF,1 -> 1; each out_valid 1 cycle after accept.
REQ-036 ADD 0x7FFFFFFF+1 -> result 0x80000000, ovf 1; SUB 5-5 -> result 0, zero 1, ovf 0.
REQ-037 Macro defined: MULTU 0xFFFFFFFF*2 -> result_hi 1, result 0xFFFFFFFE, out_valid exactly 33 cycles after accept; DIVU 100/7 -> result 14, result_hi 2; DIVU 9/0 -> result 0xFFFFFFFF, result_hi 9, dbz 1, latency 1.
REQ-038 Backpressure: out_ready held 0 for 5 cycles after out_valid -> outputs stable, in_ready 0, in_valid pulses ignored; out_ready 1 -> IDLE next edge.
REQ-039 rst asserted 10 cycles into MULTU -> next cycle out_valid 0, in_ready 1, all outputs 0; following ADD 1+1 -> 2.
REQ-040 Macro undefined: op 1000 -> illegal 1, result 0, latency 1; op 1111 -> illegal 1 under both configurations.
